// File: rtl/sweep_controller_if.sv
// -----------------------------------------------------------------------------
// sweep_controller_if
// Bundles the control and status signals of the sweep controller.
//   start, stop, pause      : control requests from the register/control logic
//   lo, hi, mode, n_sweeps  : run configuration, captured on an accepted start
//   cont, dir               : current count value and counting direction
//   busy, done, cfg_err     : run status, completion pulse, rejected-start pulse
//   sweep_cnt               : sweeps completed in the current run
// master : drives control/config, observes status (control logic, testbench)
// slave  : the sweep controller itself
// -----------------------------------------------------------------------------
interface sweep_controller_if #(
   parameter int WIDTH   = 4,
   parameter int SWEEP_W = 8
);
   logic               start;
   logic               stop;
   logic               pause;
   logic [WIDTH-1:0]   lo;
   logic [WIDTH-1:0]   hi;
   logic [1:0]         mode;
   logic [SWEEP_W-1:0] n_sweeps;
   logic [WIDTH-1:0]   cont;
   logic               dir;
   logic               busy;
   logic               done;
   logic [SWEEP_W-1:0] sweep_cnt;
   logic               cfg_err;

   modport master (
      output start, stop, pause, lo, hi, mode, n_sweeps,
      input  cont, dir, busy, done, sweep_cnt, cfg_err
   );

   modport slave (
      input  start, stop, pause, lo, hi, mode, n_sweeps,
      output cont, dir, busy, done, sweep_cnt, cfg_err
   );
endinterface

// File: rtl/sweep_controller.sv
// -----------------------------------------------------------------------------
// sweep_controller
// Programmable sequencer owning the up/down sweep count register. Supports
// bounce, up-wrap, down-wrap and single up-sweep modes between latched bounds,
// an optional sweep-count limit, pause, abort and completion signalling.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : sweep_controller_if.slave (control in, count/status out)
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module sweep_controller #(
   parameter int WIDTH   = 4,
   parameter int SWEEP_W = 8
) (
   input  logic                clk,
   input  logic                reset,
   sweep_controller_if.slave   bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   localparam logic [1:0] MODE_BOUNCE = 2'b00;
   localparam logic [1:0] MODE_UPWRAP = 2'b01;
   localparam logic [1:0] MODE_DNWRAP = 2'b10;
   localparam logic [1:0] MODE_SINGLE = 2'b11;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   cont_q, cont_d;
   logic               dir_q, dir_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               cfg_err_q, cfg_err_d;
   logic [SWEEP_W-1:0] sweep_cnt_q, sweep_cnt_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [1:0]         mode_q, mode_d;
   logic [SWEEP_W-1:0] nsw_q, nsw_d;

   logic               sweep_evt_s;
   logic [SWEEP_W-1:0] sweep_inc_s;

   // State, count and latched configuration registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         cont_q      <= {WIDTH{1'b0}};
         dir_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cfg_err_q   <= 1'b0;
         sweep_cnt_q <= {SWEEP_W{1'b0}};
         lo_q        <= {WIDTH{1'b0}};
         hi_q        <= {WIDTH{1'b0}};
         mode_q      <= 2'b00;
         nsw_q       <= {SWEEP_W{1'b0}};
      end else begin
         state_q     <= state_d;
         cont_q      <= cont_d;
         dir_q       <= dir_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         cfg_err_q   <= cfg_err_d;
         sweep_cnt_q <= sweep_cnt_d;
         lo_q        <= lo_d;
         hi_q        <= hi_d;
         mode_q      <= mode_d;
         nsw_q       <= nsw_d;
      end
   end

   // Next-state logic: stop > start > pause > count step
   always_comb begin
      state_d     = state_q;
      cont_d      = cont_q;
      dir_d       = dir_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      cfg_err_d   = 1'b0;
      sweep_cnt_d = sweep_cnt_q;
      lo_d        = lo_q;
      hi_d        = hi_q;
      mode_d      = mode_q;
      nsw_d       = nsw_q;
      sweep_evt_s = 1'b0;
      sweep_inc_s = sweep_cnt_q + SWEEP_W'(1);

      case (state_q)
         ST_IDLE: begin
            if (bus.stop) begin
               busy_d = 1'b0;
            end else if (bus.start) begin
               if (bus.lo > bus.hi) begin
                  cfg_err_d = 1'b1;
               end else begin
                  lo_d        = bus.lo;
                  hi_d        = bus.hi;
                  mode_d      = bus.mode;
                  nsw_d       = bus.n_sweeps;
                  sweep_cnt_d = {SWEEP_W{1'b0}};
                  busy_d      = 1'b1;
                  state_d     = ST_RUN;
                  // Down-wrap starts at the top bound counting down
                  if (bus.mode == MODE_DNWRAP) begin
                     cont_d = bus.hi;
                     dir_d  = 1'b1;
                  end else begin
                     cont_d = bus.lo;
                     dir_d  = 1'b0;
                  end
               end
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_RUN: begin
            if (bus.stop) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end else if (bus.pause) begin
               state_d = ST_HOLD;
            end else begin
               case (mode_q)
                  MODE_BOUNCE: begin
                     // Endpoint edges only flip direction; the count dwells one cycle
                     if (!dir_q) begin
                        if (cont_q != hi_q) begin
                           cont_d = cont_q + WIDTH'(1);
                        end else begin
                           dir_d       = 1'b1;
                           sweep_evt_s = 1'b1;
                        end
                     end else begin
                        if (cont_q != lo_q) begin
                           cont_d = cont_q - WIDTH'(1);
                        end else begin
                           dir_d       = 1'b0;
                           sweep_evt_s = 1'b1;
                        end
                     end
                  end
                  MODE_UPWRAP: begin
                     if (cont_q != hi_q) begin
                        cont_d = cont_q + WIDTH'(1);
                     end else begin
                        cont_d      = lo_q;
                        sweep_evt_s = 1'b1;
                     end
                  end
                  MODE_DNWRAP: begin
                     if (cont_q != lo_q) begin
                        cont_d = cont_q - WIDTH'(1);
                     end else begin
                        cont_d      = hi_q;
                        sweep_evt_s = 1'b1;
                     end
                  end
                  MODE_SINGLE: begin
                     if (cont_q != hi_q) begin
                        cont_d = cont_q + WIDTH'(1);
                     end else begin
                        sweep_evt_s = 1'b1;
                     end
                  end
                  default: begin
                     state_d = ST_IDLE;
                     busy_d  = 1'b0;
                  end
               endcase

               // Single mode always ends after one sweep; otherwise a zero limit runs forever
               if (sweep_evt_s) begin
                  sweep_cnt_d = sweep_inc_s;
                  if ((mode_q == MODE_SINGLE) ||
                      ((nsw_q != {SWEEP_W{1'b0}}) && (sweep_inc_s == nsw_q))) begin
                     state_d = ST_IDLE;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end else begin
                     state_d = ST_RUN;
                  end
               end else begin
                  sweep_cnt_d = sweep_cnt_q;
               end
            end
         end

         ST_HOLD: begin
            if (bus.stop) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end else if (!bus.pause) begin
               // Release edge only resumes; stepping starts on the next edge
               state_d = ST_RUN;
            end else begin
               state_d = ST_HOLD;
            end
         end

         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign bus.cont      = cont_q;
   assign bus.dir       = dir_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.sweep_cnt = sweep_cnt_q;
   assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_sweep_controller.sv
// -----------------------------------------------------------------------------
// tb_sweep_controller
// Self-checking bench for sweep_controller. Each driven cycle pushes the
// expected post-edge outputs onto a scoreboard queue; after the edge the entry
// is popped and compared field by field.
// -----------------------------------------------------------------------------
module tb_sweep_controller;

   logic clk;
   logic reset;

   sweep_controller_if #(.WIDTH(4), .SWEEP_W(8)) bus ();

   sweep_controller #(.WIDTH(4), .SWEEP_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      string      tag;
      logic [3:0] cont;
      logic       dir;
      logic       busy;
      logic       done;
      logic [7:0] sc;
      logic       cfg_err;
   } exp_t;

   exp_t sb_q[$];
   int   err_cnt = 0;
   int   chk_cnt = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run can never hang
   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got=%0h exp=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic exp_t mk(input string tag, input int c, input logic d, input logic b,
                               input logic dn, input int sc, input logic ce);
      exp_t e;
      e.tag     = tag;
      e.cont    = 4'(c);
      e.dir     = d;
      e.busy    = b;
      e.done    = dn;
      e.sc      = 8'(sc);
      e.cfg_err = ce;
      return e;
   endfunction

   task automatic cfg(input int l, input int h, input logic [1:0] m, input int n);
      bus.lo       = 4'(l);
      bus.hi       = 4'(h);
      bus.mode     = m;
      bus.n_sweeps = 8'(n);
   endtask

   task automatic check_outs(input exp_t e);
      check_val({e.tag, ".cont"},    16'(bus.cont),      16'(e.cont));
      check_val({e.tag, ".dir"},     16'(bus.dir),       16'(e.dir));
      check_val({e.tag, ".busy"},    16'(bus.busy),      16'(e.busy));
      check_val({e.tag, ".done"},    16'(bus.done),      16'(e.done));
      check_val({e.tag, ".sweep"},   16'(bus.sweep_cnt), 16'(e.sc));
      check_val({e.tag, ".cfg_err"}, 16'(bus.cfg_err),   16'(e.cfg_err));
   endtask

   // Drive one cycle of control, queue the expectation, compare after the edge
   task automatic cyc(input logic st, input logic sp, input logic ps, input exp_t e);
      exp_t got;
      bus.start = st;
      bus.stop  = sp;
      bus.pause = ps;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      got = sb_q.pop_front();
      check_outs(got);
   endtask

   initial begin
      reset     = 1'b0;
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      bus.pause = 1'b0;
      cfg(0, 0, 2'b00, 0);
      repeat (2) @(posedge clk);
      #1;
      check_outs(mk("rst", 0, 1'b0, 1'b0, 1'b0, 0, 1'b0));
      reset = 1'b1;

      // Idle with no start
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, mk("idle", 0, 1'b0, 1'b0, 1'b0, 0, 1'b0));

      // Bounce 2..5, two sweeps
      cfg(2, 5, 2'b00, 2);
      cyc(1'b1, 1'b0, 1'b0, mk("bnc", 2, 1'b0, 1'b1, 1'b0, 0, 1'b0));
      for (int v = 3; v <= 5; v++) cyc(1'b0, 1'b0, 1'b0, mk("bnc", v, 1'b0, 1'b1, 1'b0, 0, 1'b0));
      cyc(1'b0, 1'b0, 1'b0, mk("bnc_top", 5, 1'b1, 1'b1, 1'b0, 1, 1'b0));
      for (int v = 4; v >= 2; v--) cyc(1'b0, 1'b0, 1'b0, mk("bnc", v, 1'b1, 1'b1, 1'b0, 1, 1'b0));
      cyc(1'b0, 1'b0, 1'b0, mk("bnc_done", 2, 1'b0, 1'b0, 1'b1, 2, 1'b0));
      cyc(1'b0, 1'b0, 1'b0, mk("bnc_hold", 2, 1'b0, 1'b0, 1'b0, 2, 1'b0));

      // Up-wrap full range, one sweep
      cfg(0, 15, 2'b01, 1);
      cyc(1'b1, 1'b0, 1'b0, mk("upw", 0, 1'b0, 1'b1, 1'b0, 0, 1'b0));
      for (int v = 1; v <= 15; v++) cyc(1'b0, 1'b0, 1'b0, mk("upw", v, 1'b0, 1'b1, 1'b0, 0, 1'b0));
      cyc(1'b0, 1'b0, 1'b0, mk("upw_done", 0, 1'b0, 1'b0, 1'b1, 1, 1'b0));
      cyc(1'b0, 1'b0, 1'b0, mk("upw_hold", 0, 1'b0, 1'b0, 1'b0, 1, 1'b0));

      // Down-wrap 3..6, one sweep
      cfg(3, 6, 2'b10, 1);
      cyc(1'b1, 1'b0, 1'b0, mk("dnw", 6, 1'b1, 1'b1, 1'b0, 0, 1'b0));
      for (int v = 5; v >= 3; v--) cyc(1'b0, 1'b0, 1'b0, mk("dnw", v, 1'b1, 1'b1, 1'b0, 0, 1'b0));
      cyc(1'b0, 1'b0, 1'b0, mk("dnw_done", 6, 1'b1, 1'b0, 1'b1, 1, 1'b0));
      cyc(1'b0, 1'b0, 1'b0, mk("dnw_hold", 6, 1'b1, 1'b0, 1'b0, 1, 1'b0));

      // Bounce forever with pause and stop
      cfg(0, 15, 2'b00, 0);
      cyc(1'b1, 1'b0, 1'b0, mk("ps", 0, 1'b0, 1'b1, 1'b0, 0, 1'b0));
      for (int v = 1; v <= 7; v++) cyc(1'b0, 1'b0, 1'b0, mk("ps", v, 1'b0, 1'b1, 1'b0, 0, 1'b0));
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, mk("ps_hold", 7, 1'b0, 1'b1, 1'b0, 0, 1'b0));
      cyc(1'b0, 1'b0, 1'b0, mk("ps_rel", 7, 1'b0, 1'b1, 1'b0, 0, 1'b0));
      for (int v = 8; v <= 10; v++) cyc(1'b0, 1'b0, 1'b0, mk("ps", v, 1'b0, 1'b1, 1'b0, 0, 1'b0));
      cyc(1'b0, 1'b1, 1'b0, mk("ps_stop", 10, 1'b0, 1'b0, 1'b0, 0, 1'b0));
      cyc(1'b0, 1'b0, 1'b0, mk("ps_idle", 10, 1'b0, 1'b0, 1'b0, 0, 1'b0));

      // Rejected start (lo > hi)
      cfg(9, 4, 2'b01, 0);
      cyc(1'b1, 1'b0, 1'b0, mk("cerr", 10, 1'b0, 1'b0, 1'b0, 0, 1'b1));
      cyc(1'b0, 1'b0, 1'b0, mk("cerr_end", 10, 1'b0, 1'b0, 1'b0, 0, 1'b0));

      // start together with stop in IDLE does nothing
      cfg(1, 3, 2'b01, 0);
      cyc(1'b1, 1'b1, 1'b0, mk("sst", 10, 1'b0, 1'b0, 1'b0, 0, 1'b0));
      cyc(1'b0, 1'b0, 1'b0, mk("sst", 10, 1'b0, 1'b0, 1'b0, 0, 1'b0));

      // start during RUN is ignored; original 1..3 wrap config stays
      cyc(1'b1, 1'b0, 1'b0, mk("rst_run", 1, 1'b0, 1'b1, 1'b0, 0, 1'b0));
      cfg(0, 15, 2'b00, 1);
      cyc(1'b1, 1'b0, 1'b0, mk("rst_run", 2, 1'b0, 1'b1, 1'b0, 0, 1'b0));
      cyc(1'b1, 1'b0, 1'b0, mk("rst_run", 3, 1'b0, 1'b1, 1'b0, 0, 1'b0));
      cyc(1'b1, 1'b0, 1'b0, mk("rst_run_wrap", 1, 1'b0, 1'b1, 1'b0, 1, 1'b0));
      cyc(1'b0, 1'b1, 1'b0, mk("rst_run_stop", 1, 1'b0, 1'b0, 1'b0, 1, 1'b0));

      // Single mode with lo == hi completes on the first edge
      cfg(8, 8, 2'b11, 5);
      cyc(1'b1, 1'b0, 1'b0, mk("sgl", 8, 1'b0, 1'b1, 1'b0, 0, 1'b0));
      cyc(1'b0, 1'b0, 1'b0, mk("sgl_done", 8, 1'b0, 1'b0, 1'b1, 1, 1'b0));
      cyc(1'b0, 1'b0, 1'b0, mk("sgl_hold", 8, 1'b0, 1'b0, 1'b0, 1, 1'b0));

      // Bounce with lo == hi: every edge flips direction and counts a sweep
      cfg(4, 4, 2'b00, 3);
      cyc(1'b1, 1'b0, 1'b0, mk("deg", 4, 1'b0, 1'b1, 1'b0, 0, 1'b0));
      cyc(1'b0, 1'b0, 1'b0, mk("deg", 4, 1'b1, 1'b1, 1'b0, 1, 1'b0));
      cyc(1'b0, 1'b0, 1'b0, mk("deg", 4, 1'b0, 1'b1, 1'b0, 2, 1'b0));
      cyc(1'b0, 1'b0, 1'b0, mk("deg_done", 4, 1'b1, 1'b0, 1'b1, 3, 1'b0));

      // Asynchronous reset mid-run
      cfg(0, 15, 2'b00, 0);
      cyc(1'b1, 1'b0, 1'b0, mk("mrst", 0, 1'b0, 1'b1, 1'b0, 0, 1'b0));
      for (int v = 1; v <= 3; v++) cyc(1'b0, 1'b0, 1'b0, mk("mrst", v, 1'b0, 1'b1, 1'b0, 0, 1'b0));
      #2;
      reset = 1'b0;
      #1;
      check_outs(mk("mrst_async", 0, 1'b0, 1'b0, 1'b0, 0, 1'b0));
      @(posedge clk);
      #1;
      check_outs(mk("mrst_held", 0, 1'b0, 1'b0, 1'b0, 0, 1'b0));
      reset = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, mk("mrst_idle", 0, 1'b0, 1'b0, 1'b0, 0, 1'b0));
      cyc(1'b0, 1'b0, 1'b0, mk("mrst_idle", 0, 1'b0, 1'b0, 1'b0, 0, 1'b0));

      check_val("sb_empty", 16'(sb_q.size()), 16'd0);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
